serializer_scheduler: RTL and testbench
=======================================

// Module: serializer_scheduler
// PURPOSE
//  Shares one paraleloSerial-type serializer among NUM_REQ parallel-word requesters.
//  Keeps a word-slot counter phase-aligned with the serializer's bit counter.
//  At each word boundary it presents either:
//   - the next word, picked round-robin among active requesters, or
//   - an idle/comma word when no requester is active.
//  Sits between the per-channel framing logic and the serializer's 'entradas' input.
//  Also sequences link start-up: sends N_SYNC idle words after every reset.
// PARAMETERS
//  CANT_BITS  10            word width; also bit cycles per word slot (>=2)
//  NUM_REQ    4             number of requesters (2..8)
//  N_SYNC     2             idle words forced after reset before any grant (>=1)
//  IDLE_WORD  10'b0011111010 word sent when idle (K28.5, RD-)
// PORTS
//  clk          in   1                 system bit clock
//  rst          in   1                 synchronous reset, active-high
//  enb          in   1                 enable; low freezes all state
//  req          in   NUM_REQ           request per channel; level, held until ack
//  datos        in   NUM_REQ*CANT_BITS word of channel i at [i*CANT_BITS +: CANT_BITS]
//  ack          out  NUM_REQ           one-hot, one-cycle grant pulse
//  palabra      out  CANT_BITS         word driven to the serializer 'entradas'
//  inicio_trama out  1                 high in the first bit cycle of each word slot
//  canal        out  clog2(NUM_REQ)    source of 'palabra'; 0 when idle
//  ocupado      out  1                 high while state is TRANSMITE
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - outputs: palabra=IDLE_WORD, ack=0, inicio_trama=0, canal=0, ocupado=0
//   - internal: cnt=0, rr pointer=0, sync count=0, state=INICIO
//   - reset overrides enb; reset mid-word abandons the word (no ack is issued)
//  Slot counter cnt (clog2(CANT_BITS) bits)
//   - updates only when enb=1: cnt <= (cnt==0) ? CANT_BITS-1 : cnt-1
//   - this matches the serializer's own counter, so both wrap on the same edge
//  Boundary edge = posedge with enb=1 && cnt==0. At that edge only:
//   - load palabra and canal
//   - set inicio_trama=1
//   - set ack, one-hot at the winner bit, only when a grant is made
//   - on the next enabled edge, ack and inicio_trama return to 0
//   - between boundaries, palabra and canal hold
//  Word latency
//   - req and datos are sampled only at the boundary edge
//   - the granted word is on palabra in the first cycle after that edge
//   - data must be stable only at the sampling edge
//  Round-robin arbitration
//   - search starts at pointer p: p, p+1, ... NUM_REQ-1, 0, ..., p-1
//   - first active req wins
//   - on a grant, p <= winner+1 (mod NUM_REQ); with no grant, p holds
//  FSM (transitions evaluated only at boundary edges)
//   - INICIO:    send IDLE_WORD, sync++; ignore req; go to ESPERA when sync reaches N_SYNC
//   - ESPERA:    any req -> grant, go to TRANSMITE; none -> IDLE_WORD, stay
//   - TRANSMITE: any req -> grant, stay; none -> IDLE_WORD, go to ESPERA
//   - ocupado is registered and reflects the state after each edge
//  Boundary conditions
//   - enb low: cnt, FSM, pointer, palabra and canal hold
//     - ack and inicio_trama are held at 0 while enb=0
//     - the slot resumes where it stopped
//   - requester holding req after ack is granted again only at a later boundary
//     - it gets the slot again only if no other requester is active
//   - req dropped before the boundary: no grant to that channel
//   - all requesters active: strict rotation, one word each per NUM_REQ slots
// TESTING
//  1. rst 3 cycles, enb=1, req=0 -> palabra=0x0FA;
//     inicio_trama pulses at cycles 1,11,21,...; ack never set; ocupado=0.
//  2. Release rst with req=4'b1111 -> idle words at cycles 1 and 11;
//     grants at cycles 21/31/41/51 to ch 0/1/2/3 (ack=0001,0010,0100,1000);
//     ch0 is granted again at 61.
//  3. Only req[2]=1, datos[2]=0x2AA, after sync -> palabra=0x2AA every slot;
//     canal=2 and ocupado=1 throughout; on dropping req, the next slot is IDLE_WORD and ocupado=0.
//  4. enb=0 for 5 cycles at cnt=4 -> all outputs frozen; next inicio_trama arrives 5 cycles late.
//  5. rst pulse at cnt=6 while TRANSMITE -> all outputs back to reset values next cycle;
//     2 idle words are sent before any new grant.
//  6. req={ch1,ch3} with p=2 -> ch3 granted first, then ch1; ack is never multi-hot.

Source files
------------

// File: rtl/serializer_scheduler.sv
// serializer_scheduler: round-robin word scheduler that feeds a shared serializer, inserting idle words when no requester is active
module serializer_scheduler #(
    parameter int                 CANT_BITS = 10,
    parameter int                 NUM_REQ   = 4,
    parameter int                 N_SYNC    = 2,
    parameter logic [CANT_BITS-1:0] IDLE_WORD = 10'b0011111010
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enb,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*CANT_BITS-1:0] datos,
    output logic [NUM_REQ-1:0]           ack,
    output logic [CANT_BITS-1:0]         palabra,
    output logic                         inicio_trama,
    output logic [$clog2(NUM_REQ)-1:0]   canal,
    output logic                         ocupado
);
    localparam int CW = $clog2(CANT_BITS);
    localparam int PW = $clog2(NUM_REQ);
    localparam int SW = $clog2(N_SYNC + 1);

    typedef enum logic [1:0] {INICIO, ESPERA, TRANSMITE} state_t;

    state_t          r_state, w_nstate;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_ptr, w_win, w_idx;
    logic [SW-1:0]   r_sync, w_nsync;
    logic            w_bnd, w_found, w_grant;

    assign w_bnd = enb && (r_cnt == '0);

    // Rotating priority search starting at the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_nsync  = r_sync;
        w_grant  = 1'b0;
        if (w_bnd) begin
            case (r_state)
                INICIO: begin
                    w_nsync  = r_sync + 1'b1;
                    w_nstate = (w_nsync == SW'(N_SYNC)) ? ESPERA : INICIO;
                end
                ESPERA: begin
                    w_grant  = w_found;
                    w_nstate = w_found ? TRANSMITE : ESPERA;
                end
                TRANSMITE: begin
                    w_grant  = w_found;
                    w_nstate = w_found ? TRANSMITE : ESPERA;
                end
                default: w_nstate = INICIO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= INICIO;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_sync       <= '0;
            palabra      <= IDLE_WORD;
            canal        <= '0;
            ack          <= '0;
            inicio_trama <= 1'b0;
            ocupado      <= 1'b0;
        end else begin
            ack          <= '0;
            inicio_trama <= 1'b0;
            if (enb) begin
                r_cnt   <= (r_cnt == '0) ? CW'(CANT_BITS - 1) : r_cnt - 1'b1;
                r_state <= w_nstate;
                r_sync  <= w_nsync;
                ocupado <= (w_nstate == TRANSMITE);
                if (w_bnd) begin
                    inicio_trama <= 1'b1;
                    palabra      <= w_grant ? datos[w_win*CANT_BITS +: CANT_BITS] : IDLE_WORD;
                    canal        <= w_grant ? w_win : '0;
                    ack          <= w_grant ? (NUM_REQ'(1) << w_win) : '0;
                    r_ptr        <= w_grant ? ((w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1) : r_ptr;
                end
            end
        end
    end
endmodule

// File: tb/tb_serializer_scheduler.sv
// tb_serializer_scheduler: slot-level vector table plus hand sequences for enable freeze and mid-word reset
module tb_serializer_scheduler;
    localparam logic [9:0] IDLE = 10'h0FA;
    localparam logic [9:0] W0 = 10'h101, W1 = 10'h0C3, W2 = 10'h2AA, W3 = 10'h355;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enb = 1'b1;
    logic [3:0]  req = 4'h0;
    logic [39:0] datos;
    logic [3:0]  ack;
    logic [9:0]  palabra;
    logic        inicio_trama;
    logic [1:0]  canal;
    logic        ocupado;

    int n_cmp = 0;
    int n_err = 0;

    assign datos = {W3, W2, W1, W0};

    serializer_scheduler dut (
        .clk(clk), .rst(rst), .enb(enb), .req(req), .datos(datos),
        .ack(ack), .palabra(palabra), .inicio_trama(inicio_trama),
        .canal(canal), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rstb;
        logic [3:0] req;
        logic [3:0] ack;
        logic [1:0] canal;
        logic [9:0] pal;
        bit         oc;
    } vec_t;

    vec_t tbl[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_palabra"}, 32'(palabra), 32'(IDLE));
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_inicio"}, 32'(inicio_trama), 0);
        chk({tag, "_canal"}, 32'(canal), 0);
        chk({tag, "_ocupado"}, 32'(ocupado), 0);
    endtask

    task automatic slot(input logic [3:0] r, input logic [3:0] ea, input logic [1:0] ec,
                        input logic [9:0] ep, input bit eo, input string tag);
        bit bad;
        req = r;
        tick();
        chk({tag, "_inicio"}, 32'(inicio_trama), 1);
        chk({tag, "_ack"}, 32'(ack), 32'(ea));
        chk({tag, "_canal"}, 32'(canal), 32'(ec));
        chk({tag, "_palabra"}, 32'(palabra), 32'(ep));
        chk({tag, "_ocupado"}, 32'(ocupado), 32'(eo));
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            bad |= inicio_trama | (|ack) | (palabra != ep) | (canal != ec);
        end
        chk({tag, "_hold"}, 32'(bad), 0);
    endtask

    initial begin
        int k;
        tbl[0]  = '{1, 4'h0, 4'h0, 2'd0, IDLE, 0};
        tbl[1]  = '{0, 4'h0, 4'h0, 2'd0, IDLE, 0};
        tbl[2]  = '{0, 4'h0, 4'h0, 2'd0, IDLE, 0};
        tbl[3]  = '{1, 4'hF, 4'h0, 2'd0, IDLE, 0};
        tbl[4]  = '{0, 4'hF, 4'h0, 2'd0, IDLE, 0};
        tbl[5]  = '{0, 4'hF, 4'h1, 2'd0, W0,   1};
        tbl[6]  = '{0, 4'hF, 4'h2, 2'd1, W1,   1};
        tbl[7]  = '{0, 4'hF, 4'h4, 2'd2, W2,   1};
        tbl[8]  = '{0, 4'hF, 4'h8, 2'd3, W3,   1};
        tbl[9]  = '{0, 4'hF, 4'h1, 2'd0, W0,   1};
        tbl[10] = '{0, 4'h4, 4'h4, 2'd2, W2,   1};
        tbl[11] = '{0, 4'h4, 4'h4, 2'd2, W2,   1};
        tbl[12] = '{0, 4'h0, 4'h0, 2'd0, IDLE, 0};
        tbl[13] = '{0, 4'h2, 4'h2, 2'd1, W1,   1};
        tbl[14] = '{0, 4'hA, 4'h8, 2'd3, W3,   1};
        tbl[15] = '{0, 4'hA, 4'h2, 2'd1, W1,   1};
        tbl[16] = '{0, 4'h0, 4'h0, 2'd0, IDLE, 0};

        for (int v = 0; v < 17; v++) begin
            if (tbl[v].rstb) begin
                rst = 1'b1;
                req = tbl[v].req;
                repeat (3) tick();
                chk_reset($sformatf("v%0d_rst", v));
                rst = 1'b0;
            end
            slot(tbl[v].req, tbl[v].ack, tbl[v].canal, tbl[v].pal, tbl[v].oc, $sformatf("v%0d", v));
        end

        // enable freeze at cnt=4
        req = 4'h4;
        tick();
        chk("frz_grant", 32'(ack), 32'h4);
        repeat (5) tick();
        enb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("frz_c%0d", i),
                {16'h0, inicio_trama, ack, canal, ocupado, palabra[7:0]},
                {16'h0, 1'b0, 4'h0, 2'd2, 1'b1, W2[7:0]});
        end
        enb = 1'b1;
        k = 0;
        while (!inicio_trama && k < 20) begin
            tick();
            k++;
        end
        chk("frz_late", 32'(k), 5);
        chk("frz_regrant", 32'(ack), 32'h4);
        chk("frz_pal", 32'(palabra), 32'(W2));

        // reset at cnt=6 while transmitting
        repeat (3) tick();
        chk("mid_busy", 32'(ocupado), 1);
        rst = 1'b1;
        tick();
        chk_reset("mid_rst");
        rst = 1'b0;
        slot(4'hF, 4'h0, 2'd0, IDLE, 0, "mid_s0");
        slot(4'hF, 4'h0, 2'd0, IDLE, 0, "mid_s1");
        slot(4'hF, 4'h1, 2'd0, W0,   1, "mid_s2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
